// File: rtl/reg_file_sb.sv
// reg_file_sb: integer register file with two read ports, writeback and
// load-return write ports, optional write-to-read bypass and a per-register
// load scoreboard (busy bits plus a registered pending-load count).
module reg_file_sb #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned AW     = 5,
    parameter int unsigned BYPASS = 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic [AW-1:0]   A1,
    input  logic [AW-1:0]   A2,
    output logic [XLEN-1:0] RD1,
    output logic [XLEN-1:0] RD2,
    output logic            BUSY1,
    output logic            BUSY2,
    input  logic [AW-1:0]   A3,
    input  logic [XLEN-1:0] WD,
    input  logic            WE,
    input  logic            SET_BUSY,
    input  logic [AW-1:0]   SB_ADDR,
    input  logic            LD_WE,
    input  logic [AW-1:0]   LD_ADDR,
    input  logic [XLEN-1:0] LD_WD,
    output logic [AW:0]     PEND_CNT
);

    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0]  mem_q [NREGS];
    logic [XLEN-1:0]  mem_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic [CW-1:0]    pend_cnt_q;
    logic [CW-1:0]    pend_cnt_d;

    // Next register contents; load return applied first so writeback wins a collision
    always_comb begin
        mem_d = mem_q;
        if (LD_WE && (LD_ADDR != '0)) begin
            mem_d[LD_ADDR] = LD_WD;
        end
        if (WE && (A3 != '0)) begin
            mem_d[A3] = WD;
        end
    end

    // Next busy bits; a new load marking wins over a same-cycle load return
    always_comb begin
        busy_d = busy_q;
        if (LD_WE) begin
            busy_d[LD_ADDR] = 1'b0;
        end
        if (SET_BUSY) begin
            busy_d[SB_ADDR] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Pending count tracks the population of the next busy vector
    always_comb begin
        pend_cnt_d = '0;
        for (int unsigned i = 0; i < NREGS; i++) begin
            pend_cnt_d = pend_cnt_d + CW'(busy_d[i]);
        end
    end

    // State registers, cleared asynchronously
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                mem_q[i] <= '0;
            end
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    // Read data for one port: x0 and reset force zero, then optional forwarding
    function automatic logic [XLEN-1:0] read_data(input logic [AW-1:0] a);
        logic [XLEN-1:0] r;
        r = mem_q[a];
        if (BYPASS != 0) begin
            if (WE && (A3 == a)) begin
                r = WD;
            end else if (LD_WE && (LD_ADDR == a)) begin
                r = LD_WD;
            end
        end
        if ((a == '0) || !RST) begin
            r = '0;
        end
        return r;
    endfunction

    // Busy for one port: a load returning this cycle already satisfies the operand
    function automatic logic read_busy(input logic [AW-1:0] a);
        logic b;
        b = busy_q[a];
        if ((BYPASS != 0) && LD_WE && (LD_ADDR == a)) begin
            b = 1'b0;
        end
        if ((a == '0) || !RST) begin
            b = 1'b0;
        end
        return b;
    endfunction

    // Combinational read ports
    always_comb begin
        RD1   = read_data(A1);
        RD2   = read_data(A2);
        BUSY1 = read_busy(A1);
        BUSY2 = read_busy(A2);
    end

    assign PEND_CNT = pend_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: one bypassing and one non-bypassing instance share
// stimulus; directed scenarios followed by random traffic against a model.
module tb_reg_file_sb;

    logic        clk;
    logic        rst_n;
    logic [4:0]  a1, a2, a3, sb_addr, ld_addr;
    logic [31:0] wd, ld_wd;
    logic        we, sb, ld_we;

    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;
    logic        busy1_b, busy2_b, busy1_n, busy2_n;
    logic [5:0]  pend_b, pend_n;

    int checks = 0;
    int errors = 0;

    logic [31:0] m_mem  [32];
    bit          m_busy [32];
    int          m_pend;

    reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(1)) dut_byp (
        .CLK(clk), .RST(rst_n), .A1(a1), .A2(a2), .RD1(rd1_b), .RD2(rd2_b),
        .BUSY1(busy1_b), .BUSY2(busy2_b), .A3(a3), .WD(wd), .WE(we),
        .SET_BUSY(sb), .SB_ADDR(sb_addr), .LD_WE(ld_we), .LD_ADDR(ld_addr),
        .LD_WD(ld_wd), .PEND_CNT(pend_b)
    );

    reg_file_sb #(.XLEN(32), .NREGS(32), .AW(5), .BYPASS(0)) dut_nb (
        .CLK(clk), .RST(rst_n), .A1(a1), .A2(a2), .RD1(rd1_n), .RD2(rd2_n),
        .BUSY1(busy1_n), .BUSY2(busy2_n), .A3(a3), .WD(wd), .WE(we),
        .SET_BUSY(sb), .SB_ADDR(sb_addr), .LD_WE(ld_we), .LD_ADDR(ld_addr),
        .LD_WD(ld_wd), .PEND_CNT(pend_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_pend = 0;
    endtask

    // Expected read data from the architectural rules
    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 32'd0;
        if (byp && we && a3 == a) return wd;
        if (byp && ld_we && ld_addr == a) return ld_wd;
        return m_mem[a];
    endfunction

    function automatic logic m_bsy(input logic [4:0] a, input bit byp);
        if (!rst_n || a == 5'd0) return 1'b0;
        if (byp && ld_we && ld_addr == a) return 1'b0;
        return m_busy[a];
    endfunction

    // Architectural effect of one rising edge
    task automatic model_edge();
        if (ld_we && ld_addr != 5'd0) m_mem[ld_addr] = ld_wd;
        if (we && a3 != 5'd0) m_mem[a3] = wd;
        if (ld_we) m_busy[ld_addr] = 1'b0;
        if (sb && sb_addr != 5'd0) m_busy[sb_addr] = 1'b1;
        m_pend = 0;
        foreach (m_busy[i]) if (m_busy[i]) m_pend++;
    endtask

    task automatic check_outputs();
        chk("rd1_byp",   rd1_b,   m_rd(a1, 1'b1));
        chk("rd2_byp",   rd2_b,   m_rd(a2, 1'b1));
        chk("busy1_byp", 32'(busy1_b), 32'(m_bsy(a1, 1'b1)));
        chk("busy2_byp", 32'(busy2_b), 32'(m_bsy(a2, 1'b1)));
        chk("rd1_nb",    rd1_n,   m_rd(a1, 1'b0));
        chk("rd2_nb",    rd2_n,   m_rd(a2, 1'b0));
        chk("busy1_nb",  32'(busy1_n), 32'(m_bsy(a1, 1'b0)));
        chk("busy2_nb",  32'(busy2_n), 32'(m_bsy(a2, 1'b0)));
        chk("pend_byp",  32'(pend_b), 32'(m_pend));
        chk("pend_nb",   32'(pend_n), 32'(m_pend));
    endtask

    // Check current outputs, then advance one edge and update the model
    task automatic cycle();
        #1;
        check_outputs();
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
    endtask

    task automatic idle();
        we = 1'b0; ld_we = 1'b0; sb = 1'b0;
        a3 = 5'd0; sb_addr = 5'd0; ld_addr = 5'd0;
        wd = 32'd0; ld_wd = 32'd0;
    endtask

    initial begin
        model_reset();
        rst_n = 1'b0;
        idle();
        a1 = 5'd0; a2 = 5'd0;

        // Reset state, with a bypass candidate present during reset
        #2;
        we = 1'b1; a3 = 5'd3; wd = 32'h1234_5678; a1 = 5'd3;
        #1;
        chk("rst_rd1_byp", rd1_b, 32'd0);
        chk("rst_pend", 32'(pend_b), 32'd0);
        check_outputs();
        #5;
        rst_n = 1'b1;
        idle();

        // Reset clear: x5 written and x9 busy, then asynchronous reset mid-cycle
        we = 1'b1; a3 = 5'd5; wd = 32'hDEAD_BEEF; sb = 1'b1; sb_addr = 5'd9;
        cycle();
        idle(); a1 = 5'd5; a2 = 5'd9;
        #1;
        chk("pre_rst_rd1", rd1_b, 32'hDEAD_BEEF);
        chk("pre_rst_busy2", 32'(busy2_b), 32'd1);
        chk("pre_rst_pend", 32'(pend_b), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_rd1", rd1_b, 32'd0);
        chk("async_rst_rd1_nb", rd1_n, 32'd0);
        chk("async_rst_busy2", 32'(busy2_b), 32'd0);
        chk("async_rst_pend", 32'(pend_b), 32'd0);
        #2;
        rst_n = 1'b1;

        // Write/read sweep
        for (int i = 0; i < 32; i++) begin
            we = 1'b1; a3 = 5'(i); wd = 32'(i);
            cycle();
        end
        idle();
        for (int i = 0; i < 32; i++) begin
            a1 = 5'(i); a2 = 5'(31 - i);
            #1;
            chk("sweep_rd1", rd1_n, (i == 0) ? 32'd0 : 32'(i));
            chk("sweep_rd2", rd2_n, (i == 31) ? 32'd0 : 32'(31 - i));
            cycle();
        end

        // Bypass vs stored value
        we = 1'b1; a3 = 5'd7; wd = 32'd3;
        cycle();
        a1 = 5'd7; wd = 32'd9;
        #1;
        chk("bypass_rd1_byp", rd1_b, 32'd9);
        chk("bypass_rd1_nb", rd1_n, 32'd3);
        cycle();
        idle(); a1 = 5'd7;
        #1;
        chk("bypass_after_nb", rd1_n, 32'd9);

        // Scoreboard set, forwarded load return, count drop
        sb = 1'b1; sb_addr = 5'd4;
        cycle();
        idle(); a1 = 5'd4;
        #1;
        chk("sb_busy1", 32'(busy1_b), 32'd1);
        chk("sb_pend", 32'(pend_b), 32'd1);
        ld_we = 1'b1; ld_addr = 5'd4; ld_wd = 32'h55;
        #1;
        chk("ld_busy1_byp", 32'(busy1_b), 32'd0);
        chk("ld_rd1_byp", rd1_b, 32'h55);
        chk("ld_busy1_nb", 32'(busy1_n), 32'd1);
        cycle();
        idle(); a1 = 5'd4;
        #1;
        chk("ld_pend_after", 32'(pend_b), 32'd0);
        chk("ld_rd1_after_nb", rd1_n, 32'h55);

        // Collision: writeback beats load return on data
        we = 1'b1; a3 = 5'd6; wd = 32'd1; ld_we = 1'b1; ld_addr = 5'd6; ld_wd = 32'd2;
        cycle();
        idle(); a1 = 5'd6;
        #1;
        chk("coll_wd_wins", rd1_n, 32'd1);

        // Collision: set beats load return on busy
        sb = 1'b1; sb_addr = 5'd8;
        cycle();
        sb = 1'b1; sb_addr = 5'd8; ld_we = 1'b1; ld_addr = 5'd8; ld_wd = 32'hABCD;
        cycle();
        idle(); a1 = 5'd8;
        #1;
        chk("coll_set_busy", 32'(busy1_b), 32'd1);
        chk("coll_set_pend", 32'(pend_b), 32'd1);
        ld_we = 1'b1; ld_addr = 5'd8; ld_wd = 32'd0;
        cycle();
        idle();

        // x0 guard
        sb = 1'b1; sb_addr = 5'd0; we = 1'b1; a3 = 5'd0; wd = 32'hFF; a1 = 5'd0;
        #1;
        chk("x0_rd1_same", rd1_b, 32'd0);
        cycle();
        idle(); a1 = 5'd0;
        #1;
        chk("x0_busy1", 32'(busy1_b), 32'd0);
        chk("x0_rd1", rd1_b, 32'd0);
        chk("x0_pend", 32'(pend_b), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            a1      = 5'($urandom_range(0, 31));
            a2      = 5'($urandom_range(0, 31));
            we      = ($urandom_range(0, 1) == 1);
            a3      = 5'($urandom_range(0, 31));
            wd      = $urandom;
            ld_we   = ($urandom_range(0, 2) == 0);
            ld_addr = ($urandom_range(0, 3) == 0) ? a1 : 5'($urandom_range(0, 31));
            ld_wd   = $urandom;
            sb      = ($urandom_range(0, 2) == 0);
            sb_addr = ($urandom_range(0, 3) == 0) ? ld_addr : 5'($urandom_range(0, 31));
            cycle();
        end
        idle();
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised register file with integrated load scoreboard. It is the next-generation replacement for the core's integer register file and sits between decode and writeback. It provides two combinational read ports and two write ports: one for ALU/writeback and one for cache-refill load return. Optional same-cycle write-to-read bypass and per-register busy bits let the pipeline stall on operands whose load missed in the data cache.

## Interface

- XLEN, 32, data width in bits
- NREGS, 32, number of architectural registers (power of two, at least 2)
- AW, 5, address width; must equal log2(NREGS)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value only
- CLK  input  1  clock, all state updates on rising edge
- RST  input  1  reset, asynchronous, active-low; clears all state
- A1, A2  input  AW  read addresses
- RD1, RD2  output  XLEN  read data (combinational)
- BUSY1, BUSY2  output  1  operand at A1/A2 awaits a pending load (combinational)
- A3  input  AW  writeback address
- WD  input  XLEN  writeback data
- WE  input  1  writeback enable
- SET_BUSY  input  1  mark SB_ADDR pending (load issued, miss)
- SB_ADDR  input  AW  destination of the pending load
- LD_WE  input  1  load return write enable
- LD_ADDR  input  AW  load return address
- LD_WD  input  XLEN  load return data
- PEND_CNT  output  AW+1  number of registers currently busy

## Operation

- Storage: NREGS x XLEN array and NREGS busy bits.
- Reset (RST=0, any time, asynchronous): all registers 0, all busy bits 0, PEND_CNT=0. Reads during reset return 0 and BUSY1/2=0.
- Register 0 is hardwired:
  - Reads return 0.
  - Writes from either port are ignored.
  - SET_BUSY to 0 is ignored; BUSY for address 0 is always 0.
- Writes at the rising edge:
  - WE writes WD to A3.
  - LD_WE writes LD_WD to LD_ADDR.
  - Same cycle, same nonzero address: WE wins. LD_WD is discarded; the busy bit still clears.
- Busy bits, at the rising edge:
  - LD_WE clears busy[LD_ADDR].
  - WE to a busy register does not clear it.
  - SET_BUSY sets busy[SB_ADDR].
  - SET_BUSY and LD_WE to the same address in the same cycle: set wins (new load re-marks the register).
  - SET_BUSY on an already-busy register: stays busy, no double count.
- PEND_CNT equals the population count of the busy bits. It is registered and updated in the same edge as the busy bits. It can never exceed NREGS-1.
- Read path with BYPASS=1, port n (A1 or A2), first matching rule applies:
  - Address 0 gives 0.
  - WE and A3 match gives WD.
  - LD_WE and LD_ADDR match gives LD_WD.
  - Otherwise the stored value.
- BUSY with BYPASS=1: busy[An] AND NOT(LD_WE and LD_ADDR==An).
- BYPASS=0:
  - RD returns the stored value (0 for address 0).
  - BUSY = busy[An], raw.

## Timing

- Read latency 0 cycles: RD and BUSY are combinational from addresses, stored state and, with BYPASS=1, the current write inputs.
- Write latency 1 edge: data is stored on the rising CLK where WE/LD_WE is high and is visible from stored state after that edge.
- SET_BUSY is visible on BUSY1/2 the cycle after the edge that samples it.
- No handshake. The pipeline must hold SET_BUSY to one cycle per load. LD_WE without a prior SET_BUSY is legal: it writes data, and the busy bit stays 0.
- Reset deassertion is synchronous to the design's clock domain. The first write is accepted on the first rising edge with RST=1.

## Test plan

- Reset clear: write 0xDEADBEEF to x5, assert RST=0 mid-cycle. Then RD1(A1=5)=0 immediately, PEND_CNT=0.
- Write/read sweep: write i to xi for i=0..31 via WE, then read A1=i, A2=31-i. Required: RD1=i, RD2=31-i, except the x0 reads return 0.
- Bypass: BYPASS=1, x7 holds 3, WE=1 A3=7 WD=9, A1=7. RD1=9 in the same cycle. BYPASS=0 gives RD1=3 that cycle and 9 after the edge.
- Scoreboard: SET_BUSY SB_ADDR=4. Next cycle BUSY1(A1=4)=1 and PEND_CNT=1.
  - LD_WE LD_ADDR=4 LD_WD=0x55 gives BUSY1=0 and RD1=0x55 in that cycle (BYPASS=1).
  - After that edge, PEND_CNT=0.
- Collisions, all on the same edge:
  - WE and LD_WE both to x6, WD=1, LD_WD=2: x6=1.
  - SET_BUSY and LD_WE both to x8: busy[8] stays 1 and PEND_CNT is unchanged.
- x0 guard: SET_BUSY SB_ADDR=0 and WE A3=0 WD=0xFF. Required: BUSY1(A1=0)=0, RD1=0, PEND_CNT=0.
